// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, arbitrates trap/EX redirects and runs a single-outstanding
// imem request/response handshake into a one-entry IF/ID buffer.
module fetch_ctrl #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            ex_redirect_valid,
    input  logic [XLEN-1:0] ex_redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_inst,
    output logic [XLEN-1:0] fetch_pc,
    output logic [15:0]     kill_cnt
);

    // state | meaning
    // BOOT  | post-reset idle cycle, no request
    // REQ   | request driven at r_fetch_pc
    // WAIT  | request accepted, awaiting its response
    // HOLD  | instruction buffered, waiting for ID
    // DROP  | awaiting a killed response; r_pend_pc holds the next PC
    typedef enum logic [2:0] {
        S_BOOT = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_pend_pc;
    logic            r_pend_valid;
    logic            r_if_valid;
    logic [XLEN-1:0] r_if_pc;
    logic [31:0]     r_if_inst;
    logic [15:0]     r_kill_cnt;

    logic            w_redir;
    logic [XLEN-1:0] w_redir_pc;
    logic [15:0]     w_kill_inc;

    // trap outranks EX when both fire together
    assign w_redir    = trap_valid | ex_redirect_valid;
    assign w_redir_pc = trap_valid ? trap_pc : ex_redirect_pc;
    assign w_kill_inc = (r_kill_cnt == 16'hFFFF) ? r_kill_cnt : r_kill_cnt + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_BOOT;
            r_fetch_pc   <= RESET_PC;
            r_pend_pc    <= '0;
            r_pend_valid <= 1'b0;
            r_if_valid   <= 1'b0;
            r_if_pc      <= '0;
            r_if_inst    <= '0;
            r_kill_cnt   <= '0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    if (w_redir) r_fetch_pc <= w_redir_pc;
                    r_state <= S_REQ;
                end
                S_REQ: begin
                    // a redirect here never retargets the in-flight address
                    if (imem_req_ready) begin
                        if (w_redir) begin
                            r_pend_pc    <= w_redir_pc;
                            r_pend_valid <= 1'b1;
                            r_state      <= S_DROP;
                        end else if (r_pend_valid) begin
                            r_state <= S_DROP;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end else if (w_redir) begin
                        r_pend_pc    <= w_redir_pc;
                        r_pend_valid <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_redir) begin
                        if (imem_rsp_valid) begin
                            r_kill_cnt <= w_kill_inc;
                            r_fetch_pc <= w_redir_pc;
                            r_state    <= S_REQ;
                        end else begin
                            r_pend_pc    <= w_redir_pc;
                            r_pend_valid <= 1'b1;
                            r_state      <= S_DROP;
                        end
                    end else if (imem_rsp_valid) begin
                        r_if_valid <= 1'b1;
                        r_if_pc    <= r_fetch_pc;
                        r_if_inst  <= imem_rsp_data;
                        r_state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_redir) begin
                        r_if_valid <= 1'b0;
                        r_fetch_pc <= w_redir_pc;
                        r_state    <= S_REQ;
                    end else if (if_ready) begin
                        r_if_valid <= 1'b0;
                        r_fetch_pc <= r_fetch_pc + XLEN'(4);
                        r_state    <= S_REQ;
                    end
                end
                S_DROP: begin
                    // newest redirect wins, even in the cycle the killed response lands
                    if (imem_rsp_valid) begin
                        r_kill_cnt   <= w_kill_inc;
                        r_fetch_pc   <= w_redir ? w_redir_pc : r_pend_pc;
                        r_pend_valid <= 1'b0;
                        r_state      <= S_REQ;
                    end else if (w_redir) begin
                        r_pend_pc <= w_redir_pc;
                    end
                end
                default: r_state <= S_BOOT;
            endcase
        end
    end

    assign imem_req_valid = (r_state == S_REQ);
    assign imem_req_addr  = r_fetch_pc;
    assign fetch_pc       = r_fetch_pc;
    assign if_valid       = r_if_valid;
    assign if_pc          = r_if_pc;
    assign if_inst        = r_if_inst;
    assign kill_cnt       = r_kill_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: normal flow, backpressure, redirects, drops, reset and PC wrap.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trap_valid = 1'b0;
    logic [63:0] trap_pc = '0;
    logic        ex_redirect_valid = 1'b0;
    logic [63:0] ex_redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [63:0] if_pc;
    logic [31:0] if_inst;
    logic [63:0] fetch_pc;
    logic [15:0] kill_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_ctrl #(.XLEN(64), .RESET_PC(64'h8000_0000)) dut (
        .clk               (clk),
        .rst               (rst),
        .trap_valid        (trap_valid),
        .trap_pc           (trap_pc),
        .ex_redirect_valid (ex_redirect_valid),
        .ex_redirect_pc    (ex_redirect_pc),
        .imem_req_valid    (imem_req_valid),
        .imem_req_ready    (imem_req_ready),
        .imem_req_addr     (imem_req_addr),
        .imem_rsp_valid    (imem_rsp_valid),
        .imem_rsp_data     (imem_rsp_data),
        .if_valid          (if_valid),
        .if_ready          (if_ready),
        .if_pc             (if_pc),
        .if_inst           (if_inst),
        .fetch_pc          (fetch_pc),
        .kill_cnt          (kill_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        step();
        imem_rsp_valid = 1'b0;
    endtask

    task automatic consume();
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
    endtask

    task automatic check_req(input string tag, input logic [63:0] addr);
        check_eq({tag, "_valid"}, {63'd0, imem_req_valid}, 64'd1);
        check_eq({tag, "_addr"}, imem_req_addr, addr);
        check_eq({tag, "_fpc"}, fetch_pc, addr);
    endtask

    task automatic check_buf(input string tag, input logic [63:0] pc, input logic [31:0] inst);
        check_eq({tag, "_ifv"}, {63'd0, if_valid}, 64'd1);
        check_eq({tag, "_ifpc"}, if_pc, pc);
        check_eq({tag, "_inst"}, {32'd0, if_inst}, {32'd0, inst});
    endtask

    initial begin
        #1;
        step();
        step();
        // reset values
        check_eq("rst_reqv", {63'd0, imem_req_valid}, 64'd0);
        check_eq("rst_addr", imem_req_addr, 64'h8000_0000);
        check_eq("rst_fpc", fetch_pc, 64'h8000_0000);
        check_eq("rst_ifv", {63'd0, if_valid}, 64'd0);
        check_eq("rst_ifpc", if_pc, 64'd0);
        check_eq("rst_inst", {32'd0, if_inst}, 64'd0);
        check_eq("rst_kill", {48'd0, kill_cnt}, 64'd0);

        // sequential fetch
        rst = 1'b0;
        step();
        check_req("f0_req", 64'h8000_0000);
        accept();
        check_eq("f0_wait_reqv", {63'd0, imem_req_valid}, 64'd0);
        respond(32'h0000_0013);
        check_buf("f0_buf", 64'h8000_0000, 32'h0000_0013);
        consume();
        check_eq("f0_ifv_clr", {63'd0, if_valid}, 64'd0);
        check_req("f1_req", 64'h8000_0004);
        accept();
        respond(32'h0010_0093);
        check_buf("f1_buf", 64'h8000_0004, 32'h0010_0093);
        consume();
        check_req("f2_req", 64'h8000_0008);
        accept();
        respond(32'h0020_0113);
        check_buf("f2_buf", 64'h8000_0008, 32'h0020_0113);

        // ID stall in HOLD
        for (int i = 0; i < 5; i++) begin
            step();
            check_buf("stall_buf", 64'h8000_0008, 32'h0020_0113);
            check_eq("stall_reqv", {63'd0, imem_req_valid}, 64'd0);
        end
        consume();
        check_req("after_stall_req", 64'h8000_000C);
        check_eq("after_stall_kill", {48'd0, kill_cnt}, 64'd0);

        // EX redirect in WAIT kills the in-flight fetch
        accept();
        ex_redirect_valid = 1'b1;
        ex_redirect_pc    = 64'h8000_0100;
        step();
        ex_redirect_valid = 1'b0;
        check_eq("drop_reqv", {63'd0, imem_req_valid}, 64'd0);
        respond(32'hDEAD_BEEF);
        check_eq("drop_ifv", {63'd0, if_valid}, 64'd0);
        check_eq("drop_kill", {48'd0, kill_cnt}, 64'd1);
        check_req("ex_redir_req", 64'h8000_0100);
        accept();
        respond(32'h0030_0193);
        check_buf("ex_redir_buf", 64'h8000_0100, 32'h0030_0193);

        // trap and EX together in HOLD: trap wins
        trap_valid        = 1'b1;
        trap_pc           = 64'h8000_0200;
        ex_redirect_valid = 1'b1;
        ex_redirect_pc    = 64'h8000_0300;
        step();
        trap_valid        = 1'b0;
        ex_redirect_valid = 1'b0;
        check_eq("prio_ifv", {63'd0, if_valid}, 64'd0);
        check_req("prio_req", 64'h8000_0200);

        // stalled request with a redirect in its second cycle
        step();
        check_req("stall_req1", 64'h8000_0200);
        ex_redirect_valid = 1'b1;
        ex_redirect_pc    = 64'h8000_0040;
        step();
        ex_redirect_valid = 1'b0;
        check_req("stall_req2", 64'h8000_0200);
        step();
        check_req("stall_req3", 64'h8000_0200);
        accept();
        check_eq("pend_drop_reqv", {63'd0, imem_req_valid}, 64'd0);
        respond(32'hBAD0_0001);
        check_eq("pend_kill", {48'd0, kill_cnt}, 64'd2);
        check_eq("pend_ifv", {63'd0, if_valid}, 64'd0);
        check_req("pend_req", 64'h8000_0040);

        // redirect coincident with the response in WAIT
        accept();
        trap_valid     = 1'b1;
        trap_pc        = 64'h8000_0500;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0002;
        step();
        trap_valid     = 1'b0;
        imem_rsp_valid = 1'b0;
        check_eq("same_kill", {48'd0, kill_cnt}, 64'd3);
        check_eq("same_ifv", {63'd0, if_valid}, 64'd0);
        check_req("same_req", 64'h8000_0500);

        // redirect beats if_ready in HOLD (no +4)
        accept();
        respond(32'h0040_0213);
        check_buf("hold_buf", 64'h8000_0500, 32'h0040_0213);
        if_ready          = 1'b1;
        ex_redirect_valid = 1'b1;
        ex_redirect_pc    = 64'h8000_0600;
        step();
        if_ready          = 1'b0;
        ex_redirect_valid = 1'b0;
        check_eq("hold_redir_ifv", {63'd0, if_valid}, 64'd0);
        check_req("hold_redir_req", 64'h8000_0600);

        // stray response in REQ is ignored
        imem_rsp_valid = 1'b1;
        step();
        imem_rsp_valid = 1'b0;
        check_req("stray_req", 64'h8000_0600);
        check_eq("stray_kill", {48'd0, kill_cnt}, 64'd3);
        check_eq("stray_ifv", {63'd0, if_valid}, 64'd0);

        // async reset while in WAIT, stray response after release
        accept();
        rst = 1'b1;
        #1;
        check_eq("arst_reqv", {63'd0, imem_req_valid}, 64'd0);
        check_eq("arst_addr", imem_req_addr, 64'h8000_0000);
        check_eq("arst_kill", {48'd0, kill_cnt}, 64'd0);
        check_eq("arst_ifpc", if_pc, 64'd0);
        step();
        rst            = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0003;
        step();
        imem_rsp_valid = 1'b0;
        check_req("post_rst_req", 64'h8000_0000);
        check_eq("post_rst_kill", {48'd0, kill_cnt}, 64'd0);
        check_eq("post_rst_ifv", {63'd0, if_valid}, 64'd0);

        // PC wraps at the top of the address space
        accept();
        respond(32'h0050_0293);
        check_buf("pre_wrap_buf", 64'h8000_0000, 32'h0050_0293);
        trap_valid = 1'b1;
        trap_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        trap_valid = 1'b0;
        check_req("wrap_top_req", 64'hFFFF_FFFF_FFFF_FFFC);
        accept();
        respond(32'h0060_0313);
        check_buf("wrap_buf", 64'hFFFF_FFFF_FFFF_FFFC, 32'h0060_0313);
        consume();
        check_req("wrap_req", 64'h0000_0000_0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
